trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Initiator side of the trap interface into the machine-mode CSR register file.
- Collects exception and interrupt requests from the pipeline, prioritises them, and drives trap, trap_src, misalign, pc and dmem_addr to the CSR block.
- Consumes the CSR block's registered mtvec_rdata/mepc_rdata to redirect fetch on trap entry and on mret.
- Owns pipe_flush, the signal the CSR block's performance counters observe.

Parameters:
- FLUSH_CYCLES, 2: cycles after a redirect during which new requests are ignored; legal range 1..7.
- MTVEC_MASK, 32'hFFFFFFFC: AND-mask applied to mtvec_rdata to form the trap target (direct mode only).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_fetch_misalign  in  1  instruction address misaligned, execute stage
- req_illegal  in  1  illegal instruction, execute stage
- req_ebreak  in  1  ebreak retiring
- req_ecall  in  1  ecall retiring
- req_load_misalign  in  1  load address misaligned, memory stage
- req_store_misalign  in  1  store address misaligned, memory stage
- irq_timer  in  1  machine timer interrupt level
- irq_ext  in  1  machine external interrupt level
- irq_en  in  1  global interrupt enable (mstatus.MIE)
- mret  in  1  mret retiring
- ex_pc  in  32  pc of the instruction in execute stage
- mem_addr  in  32  effective data address, memory stage
- mtvec_rdata  in  32  from CSR block
- mepc_rdata  in  32  from CSR block
- trap  out  1  one-cycle pulse to CSR block
- trap_src  out  5  {interrupt, code[3:0]}
- misalign  out  1  qualifies dmem_addr for mtval
- pc  out  32  value for mepc
- dmem_addr  out  32  faulting data address
- redirect  out  1  one-cycle fetch redirect
- redirect_pc  out  32  target of redirect
- pipe_flush  out  1  one-cycle flush pulse, coincident with redirect

Behaviour:
- States: IDLE, FLUSH. All outputs are registered.
- Reset: state=IDLE, flush counter=0, all outputs 0. rst overrides everything in the same cycle, including mid-FLUSH.
- IDLE, cycle T: any request sampled high selects a winner by fixed priority:
  1. fetch_misalign (code 0)
  2. illegal (2)
  3. ebreak (3)
  4. load_misalign (4)
  5. store_misalign (6)
  6. ecall (11)
  7. irq_ext (interrupt, 11)
  8. irq_timer (interrupt, 7)
  9. mret
- Interrupts count only when irq_en=1. All exceptions outrank interrupts, and interrupts outrank mret.
- Trap at T+1:
  - trap=1, trap_src={intr,code}, pc=ex_pc captured at T.
  - misalign=1 only for load/store misalign, with dmem_addr=mem_addr captured at T; otherwise misalign=0 and dmem_addr holds its previous value.
  - redirect=1, pipe_flush=1, redirect_pc=mtvec_rdata&MTVEC_MASK sampled at T.
  - State goes to FLUSH and the counter loads FLUSH_CYCLES.
- mret at T+1: redirect=1, pipe_flush=1, redirect_pc=mepc_rdata sampled at T, trap=0. State goes to FLUSH.
- FLUSH: every request and mret input is ignored and dropped, not queued. The counter decrements each cycle; when it reaches 1 the next state is IDLE. Requests are therefore next sampled FLUSH_CYCLES cycles after the pulse.
- Pulse length: trap, redirect, pipe_flush and misalign are high for exactly one cycle per event. pc, trap_src, dmem_addr and redirect_pc hold their values until the next event.
- Interrupts are level-sensitive. A level still high on return to IDLE traps again.
- Simultaneous exception + interrupt: the exception wins and the interrupt is re-evaluated after FLUSH.
- Simultaneous trap + mret: the trap wins and mret is discarded.
- mepc_rdata latency: the CSR read path lags by one cycle, so FLUSH_CYCLES≥1 guarantees an mret immediately after a trap sees the updated mepc.

Optional Feature:
- TRAP_CTRL_IRQ_EN defined: irq_timer, irq_ext and irq_en participate as specified above.
- Undefined: interrupt inputs are unused, no interrupt cause is ever produced, and trap_src[4] is constant 0.

Test Plan:
- Reset: rst=1 for 2 cycles mid-FLUSH -> all outputs 0 next cycle, state IDLE; a request one cycle after release is serviced.
- Illegal instruction: req_illegal=1 at T, ex_pc=0x00000104, mtvec_rdata=0x00000203 -> at T+1 trap=1, trap_src=5'h02, pc=0x104, redirect_pc=0x200, pipe_flush=1; all pulses low at T+2.
- Load misalign: req_load_misalign, mem_addr=0x00001001 -> misalign=1, dmem_addr=0x1001, trap_src=5'h04. A req_illegal raised during the following FLUSH_CYCLES cycles produces no trap.
- Priority: req_ecall+irq_ext+mret all high with irq_en=1 -> trap_src=5'h0B, intr=0. After FLUSH, irq_ext still high -> trap_src=5'h1B. With irq_en=0 -> no interrupt trap.
- mret after trap: trap, then mret asserted on the first IDLE cycle with mepc_rdata=0x104 -> redirect=1, redirect_pc=0x104, trap=0.
- Macro off: irq_timer=irq_en=1, no other requests -> no trap or redirect for 10 cycles.

Source files
------------

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Trap initiator toward the machine-mode CSR file. Prioritises
//                exceptions, interrupts and mret, then redirects fetch.
//                Interrupt causes are enabled by defining TRAP_CTRL_IRQ_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module trap_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] MTVEC_MASK   = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_fetch_misalign,
    input  logic        req_illegal,
    input  logic        req_ebreak,
    input  logic        req_ecall,
    input  logic        req_load_misalign,
    input  logic        req_store_misalign,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic        irq_en,
    input  logic        mret,
    input  logic [31:0] ex_pc,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mtvec_rdata,
    input  logic [31:0] mepc_rdata,
    output logic        trap,
    output logic [4:0]  trap_src,
    output logic        misalign,
    output logic [31:0] pc,
    output logic [31:0] dmem_addr,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        pipe_flush
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES);

    state_t      r_state,       w_state_nxt;
    logic [2:0]  r_cnt,         w_cnt_nxt;
    logic        r_trap,        w_trap_nxt;
    logic [4:0]  r_trap_src,    w_trap_src_nxt;
    logic        r_misalign,    w_misalign_nxt;
    logic [31:0] r_pc,          w_pc_nxt;
    logic [31:0] r_dmem_addr,   w_dmem_addr_nxt;
    logic        r_redirect,    w_redirect_nxt;
    logic [31:0] r_redirect_pc, w_redirect_pc_nxt;
    logic        r_pipe_flush,  w_pipe_flush_nxt;

    logic        w_irq_ext;
    logic        w_irq_timer;
    logic        w_take;
    logic        w_intr;
    logic [3:0]  w_code;
    logic        w_is_mis;

`ifdef TRAP_CTRL_IRQ_EN
    assign w_irq_ext   = irq_ext & irq_en;
    assign w_irq_timer = irq_timer & irq_en;
`else
    logic w_unused_irq;
    assign w_irq_ext    = 1'b0;
    assign w_irq_timer  = 1'b0;
    assign w_unused_irq = &{irq_timer, irq_ext, irq_en};
`endif

    // Fixed-priority cause select: every exception outranks every interrupt.
    always_comb begin
        w_take   = 1'b1;
        w_intr   = 1'b0;
        w_code   = 4'd0;
        w_is_mis = 1'b0;
        if (req_fetch_misalign) begin
            w_code = 4'd0;
        end else if (req_illegal) begin
            w_code = 4'd2;
        end else if (req_ebreak) begin
            w_code = 4'd3;
        end else if (req_load_misalign) begin
            w_code   = 4'd4;
            w_is_mis = 1'b1;
        end else if (req_store_misalign) begin
            w_code   = 4'd6;
            w_is_mis = 1'b1;
        end else if (req_ecall) begin
            w_code = 4'd11;
        end else if (w_irq_ext) begin
            w_intr = 1'b1;
            w_code = 4'd11;
        end else if (w_irq_timer) begin
            w_intr = 1'b1;
            w_code = 4'd7;
        end else begin
            w_take = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_trap_nxt        = 1'b0;
        w_misalign_nxt    = 1'b0;
        w_redirect_nxt    = 1'b0;
        w_pipe_flush_nxt  = 1'b0;
        w_trap_src_nxt    = r_trap_src;
        w_pc_nxt          = r_pc;
        w_dmem_addr_nxt   = r_dmem_addr;
        w_redirect_pc_nxt = r_redirect_pc;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_trap_nxt        = 1'b1;
                    w_trap_src_nxt    = {w_intr, w_code};
                    w_pc_nxt          = ex_pc;
                    w_misalign_nxt    = w_is_mis;
                    w_redirect_nxt    = 1'b1;
                    w_pipe_flush_nxt  = 1'b1;
                    w_redirect_pc_nxt = mtvec_rdata & MTVEC_MASK;
                    w_state_nxt       = ST_FLUSH;
                    w_cnt_nxt         = c_flush_load;
                    if (w_is_mis) begin
                        w_dmem_addr_nxt = mem_addr;
                    end
                end else if (mret) begin
                    w_redirect_nxt    = 1'b1;
                    w_pipe_flush_nxt  = 1'b1;
                    w_redirect_pc_nxt = mepc_rdata;
                    w_state_nxt       = ST_FLUSH;
                    w_cnt_nxt         = c_flush_load;
                end
            end
            ST_FLUSH: begin
                // Leaving on count 1 makes requests visible FLUSH_CYCLES after the pulse.
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 3'd0;
            r_trap        <= 1'b0;
            r_trap_src    <= 5'd0;
            r_misalign    <= 1'b0;
            r_pc          <= 32'd0;
            r_dmem_addr   <= 32'd0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_pipe_flush  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_trap        <= w_trap_nxt;
            r_trap_src    <= w_trap_src_nxt;
            r_misalign    <= w_misalign_nxt;
            r_pc          <= w_pc_nxt;
            r_dmem_addr   <= w_dmem_addr_nxt;
            r_redirect    <= w_redirect_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_pipe_flush  <= w_pipe_flush_nxt;
        end
    end

    assign trap        = r_trap;
    assign trap_src    = r_trap_src;
    assign misalign    = r_misalign;
    assign pc          = r_pc;
    assign dmem_addr   = r_dmem_addr;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign pipe_flush  = r_pipe_flush;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_ctrl
//  Description : Self-checking bench for trap_ctrl against a table-driven
//                cycle model of the trap/mret rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;

    localparam int unsigned FLUSH_CYCLES = 2;
`ifdef TRAP_CTRL_IRQ_EN
    localparam bit c_irq = 1'b1;
`else
    localparam bit c_irq = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_fetch_misalign = 1'b0, req_illegal = 1'b0, req_ebreak = 1'b0;
    logic        req_ecall = 1'b0, req_load_misalign = 1'b0, req_store_misalign = 1'b0;
    logic        irq_timer = 1'b0, irq_ext = 1'b0, irq_en = 1'b0, mret = 1'b0;
    logic [31:0] ex_pc = '0, mem_addr = '0, mtvec_rdata = '0, mepc_rdata = '0;
    logic        trap, misalign, redirect, pipe_flush;
    logic [4:0]  trap_src;
    logic [31:0] pc, dmem_addr, redirect_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic        m_trap = 0, m_mis = 0, m_redir = 0, m_flush = 0;
    logic [4:0]  m_src = '0;
    logic [31:0] m_pc = '0, m_daddr = '0, m_rpc = '0;
    int          busy = 0;

    trap_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MTVEC_MASK(32'hFFFF_FFFC)) dut (
        .clk(clk), .rst(rst),
        .req_fetch_misalign(req_fetch_misalign), .req_illegal(req_illegal),
        .req_ebreak(req_ebreak), .req_ecall(req_ecall),
        .req_load_misalign(req_load_misalign), .req_store_misalign(req_store_misalign),
        .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_en(irq_en), .mret(mret),
        .ex_pc(ex_pc), .mem_addr(mem_addr), .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata),
        .trap(trap), .trap_src(trap_src), .misalign(misalign), .pc(pc),
        .dmem_addr(dmem_addr), .redirect(redirect), .redirect_pc(redirect_pc),
        .pipe_flush(pipe_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [104:0] act_bus();
        return {trap, trap_src, misalign, pc, dmem_addr, redirect, redirect_pc, pipe_flush};
    endfunction

    function automatic logic [104:0] exp_bus();
        return {m_trap, m_src, m_mis, m_pc, m_daddr, m_redir, m_rpc, m_flush};
    endfunction

    // Advance one clock; the model consumes the same inputs the DUT sampled.
    task automatic tick();
        bit       reqs [8];
        int       codes[8] = '{0, 2, 3, 4, 6, 11, 11, 7};
        bit       intr [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
        bit       found;
        @(posedge clk);
        reqs = '{req_fetch_misalign, req_illegal, req_ebreak, req_load_misalign,
                 req_store_misalign, req_ecall, irq_ext & irq_en & c_irq,
                 irq_timer & irq_en & c_irq};
        m_trap = 0; m_mis = 0; m_redir = 0; m_flush = 0;
        if (rst) begin
            m_src = '0; m_pc = '0; m_daddr = '0; m_rpc = '0; busy = 0;
        end else if (busy > 0) begin
            busy--;
        end else begin
            found = 0;
            for (int i = 0; i < 8; i++) begin
                if (!found && reqs[i]) begin
                    found   = 1;
                    m_trap  = 1;
                    m_src   = {intr[i], 4'(codes[i])};
                    m_pc    = ex_pc;
                    m_mis   = (codes[i] == 4 || codes[i] == 6);
                    if (m_mis) m_daddr = mem_addr;
                    m_rpc   = mtvec_rdata & 32'hFFFF_FFFC;
                end
            end
            if (!found && mret) m_rpc = mepc_rdata;
            if (found || mret) begin
                m_redir = 1; m_flush = 1; busy = FLUSH_CYCLES;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        {req_fetch_misalign, req_illegal, req_ebreak, req_ecall} = '0;
        {req_load_misalign, req_store_misalign, irq_timer, irq_ext, irq_en, mret} = '0;
    endtask

    task automatic settle();
        clear_inputs();
        for (int i = 0; i <= FLUSH_CYCLES; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick();
        n_cmp++;
        if (act_bus() !== 105'd0) begin
            n_fail++; $display("FAIL reset_init: got %h want 0", act_bus());
        end
        rst = 0; req_illegal = 1; ex_pc = 32'h40; mtvec_rdata = 32'h100; tick();
        req_illegal = 0; tick();
        rst = 1; tick(); tick();
        n_cmp++;
        if (act_bus() !== 105'd0) begin
            n_fail++; $display("FAIL reset_mid_flush: got %h want 0", act_bus());
        end
        rst = 0; tick();
        req_illegal = 1; ex_pc = 32'h44; tick(); req_illegal = 0;
        n_cmp++;
        if (trap !== 1'b1 || pc !== 32'h44 || act_bus() !== exp_bus()) begin
            n_fail++; $display("FAIL reset_release_req: got trap=%b pc=%h want trap=1 pc=00000044", trap, pc);
        end
        settle();
    endtask

    task automatic test_illegal();
        req_illegal = 1; ex_pc = 32'h104; mtvec_rdata = 32'h203; tick(); req_illegal = 0;
        n_cmp++;
        if ({trap, trap_src, pc, redirect_pc, pipe_flush, redirect} !==
            {1'b1, 5'h02, 32'h104, 32'h200, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL illegal_trap: got trap=%b src=%h pc=%h rpc=%h fl=%b rd=%b want 1 02 104 200 1 1",
                               trap, trap_src, pc, redirect_pc, pipe_flush, redirect);
        end
        tick();
        n_cmp++;
        if ({trap, redirect, pipe_flush, misalign} !== 4'b0 || trap_src !== 5'h02 || redirect_pc !== 32'h200) begin
            n_fail++; $display("FAIL illegal_pulse_end: got %b%b%b%b src=%h rpc=%h want 0000 02 200",
                               trap, redirect, pipe_flush, misalign, trap_src, redirect_pc);
        end
        settle();
    endtask

    task automatic test_load_misalign();
        req_load_misalign = 1; mem_addr = 32'h1001; tick(); req_load_misalign = 0;
        n_cmp++;
        if ({misalign, dmem_addr, trap_src, trap} !== {1'b1, 32'h1001, 5'h04, 1'b1}) begin
            n_fail++; $display("FAIL load_misalign: got mis=%b addr=%h src=%h trap=%b want 1 1001 04 1",
                               misalign, dmem_addr, trap_src, trap);
        end
        req_illegal = 1;
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            tick();
            n_cmp++;
            if (trap !== 1'b0 || redirect !== 1'b0) begin
                n_fail++; $display("FAIL flush_ignore: cycle %0d got trap=%b redirect=%b want 0 0", i, trap, redirect);
            end
        end
        settle();
        n_cmp++;
        if (dmem_addr !== 32'h1001) begin
            n_fail++; $display("FAIL dmem_hold: got %h want 00001001", dmem_addr);
        end
    endtask

    task automatic test_priority();
        req_ecall = 1; irq_ext = 1; irq_en = 1; mret = 1; tick();
        req_ecall = 0; mret = 0;
        n_cmp++;
        if (trap !== 1'b1 || trap_src !== 5'h0B) begin
            n_fail++; $display("FAIL prio_ecall: got trap=%b src=%h want 1 0b", trap, trap_src);
        end
        for (int i = 0; i < FLUSH_CYCLES; i++) tick();
        tick();
        n_cmp++;
        if (trap !== c_irq || (c_irq && trap_src !== 5'h1B) || act_bus() !== exp_bus()) begin
            n_fail++; $display("FAIL prio_irq_after_flush: got trap=%b src=%h want trap=%b src=1b", trap, trap_src, c_irq);
        end
        for (int i = 0; i < FLUSH_CYCLES; i++) tick();
        irq_en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (trap !== 1'b0 || redirect !== 1'b0) begin
                n_fail++; $display("FAIL irq_disabled: got trap=%b redirect=%b want 0 0", trap, redirect);
            end
        end
        settle();
    endtask

    task automatic test_mret_after_trap();
        req_illegal = 1; ex_pc = 32'h104; mtvec_rdata = 32'h300; tick(); req_illegal = 0;
        for (int i = 0; i < FLUSH_CYCLES; i++) tick();
        mret = 1; mepc_rdata = 32'h104; tick(); mret = 0;
        n_cmp++;
        if ({redirect, redirect_pc, trap, pipe_flush} !== {1'b1, 32'h104, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL mret_after_trap: got rd=%b rpc=%h trap=%b fl=%b want 1 104 0 1",
                               redirect, redirect_pc, trap, pipe_flush);
        end
        settle();
    endtask

    task automatic test_irq_level();
        irq_timer = 1; irq_en = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (act_bus() !== exp_bus() || (!c_irq && (trap | redirect))) begin
                n_fail++; $display("FAIL irq_timer_level: cycle %0d got %h want %h", i, act_bus(), exp_bus());
            end
        end
        settle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst                = ($urandom_range(63) == 0);
            req_fetch_misalign = ($urandom_range(15) == 0);
            req_illegal        = ($urandom_range(11) == 0);
            req_ebreak         = ($urandom_range(11) == 0);
            req_ecall          = ($urandom_range(11) == 0);
            req_load_misalign  = ($urandom_range(11) == 0);
            req_store_misalign = ($urandom_range(11) == 0);
            mret               = ($urandom_range(5) == 0);
            if ($urandom_range(7) == 0) irq_timer = $urandom_range(1);
            if ($urandom_range(7) == 0) irq_ext   = $urandom_range(1);
            if ($urandom_range(7) == 0) irq_en    = $urandom_range(1);
            ex_pc = $urandom; mem_addr = $urandom; mtvec_rdata = $urandom; mepc_rdata = $urandom;
            tick();
            n_cmp++;
            if (act_bus() !== exp_bus()) begin
                n_fail++; $display("FAIL random: iter %0d got %h want %h", i, act_bus(), exp_bus());
            end
        end
        rst = 0;
        settle();
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_load_misalign();
        test_priority();
        test_mret_after_trap();
        test_irq_level();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
